// File: rtl/mdu_sequencer.sv
// mdu_sequencer: maps RISC-V M-extension requests onto the multi-cycle mul/div unit.
// Optional operand/result cache: define MDU_RESULT_CACHE_EN.
module mdu_sequencer #(
  parameter int TAGW = 5
) (
  input  logic            CLK,
  input  logic            RESETn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [31:0]     req_rs1,
  input  logic [31:0]     req_rs2,
  input  logic [TAGW-1:0] req_tag,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_result,
  output logic [TAGW-1:0] rsp_tag,
  output logic            mc_reset,
  output logic            mc_start,
  output logic [1:0]      mc_op,
  output logic [31:0]     mc_op1,
  output logic [31:0]     mc_op2,
  input  logic [31:0]     mc_result1,
  input  logic [31:0]     mc_result2,
  input  logic            mc_busy
);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT, FIX, RESP
  } state_t;

  localparam logic [2:0] F_MULHSU = 3'b010;

  // High word / remainder selects result2, else result1
  function automatic logic sel_hi(input logic [2:0] f3);
    return f3[2] ? f3[1] : (f3[1:0] != 2'b00);
  endfunction

  state_t      state;
  logic [2:0]  f3_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [1:0]  op_q;

  logic [1:0]  req_op;
  logic        req_dz;
  logic        req_ovf;
  logic        req_spec;
  logic [31:0] spec_res;
  logic        cap;
  logic [31:0] cap_res;
  logic        hit;
  logic [31:0] hit_res;

  assign req_op  = {req_funct3[2],
                    req_funct3[2] ? req_funct3[0]
                                  : req_funct3[1]};
  assign req_dz  = req_funct3[2] && (req_rs2 == 32'd0);
  assign req_ovf = req_funct3[2] && !req_funct3[0]
                && (req_rs1 == 32'h8000_0000)
                && (req_rs2 == 32'hFFFF_FFFF);
  assign req_spec = req_dz || req_ovf;

  // Divide-by-zero and signed-overflow results
  always_comb begin
    spec_res = '0;
    if (req_dz)
      spec_res = req_funct3[1] ? req_rs1 : 32'hFFFF_FFFF;
    else if (req_ovf)
      spec_res = req_funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  assign cap     = (state == WAIT) && !mc_busy;
  assign cap_res = sel_hi(f3_q) ? mc_result2 : mc_result1;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign mc_reset  = ~RESETn;
  assign mc_start  = (state == LAUNCH)
                  || ((state == WAIT) && mc_busy);
  assign mc_op     = op_q;
  assign mc_op1    = rs1_q;
  assign mc_op2    = rs2_q;

`ifdef MDU_RESULT_CACHE_EN
  logic        c_vld;
  logic [1:0]  c_op;
  logic [31:0] c_rs1;
  logic [31:0] c_rs2;
  logic [31:0] c_r1;
  logic [31:0] c_r2;

  assign hit = c_vld && (c_op == req_op)
            && (c_rs1 == req_rs1)
            && (c_rs2 == req_rs2);
  assign hit_res = sel_hi(req_funct3) ? c_r2 : c_r1;

  // Remember the last unit completion; special cases invalidate
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      c_vld <= 1'b0;
      c_op  <= '0;
      c_rs1 <= '0;
      c_rs2 <= '0;
      c_r1  <= '0;
      c_r2  <= '0;
    end else if (req_ready && req_valid && req_spec) begin
      c_vld <= 1'b0;
    end else if (cap) begin
      c_vld <= 1'b1;
      c_op  <= op_q;
      c_rs1 <= rs1_q;
      c_rs2 <= rs2_q;
      c_r1  <= mc_result1;
      c_r2  <= mc_result2;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  // Request sequencing, operand hold and result register
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state      <= IDLE;
      f3_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      op_q       <= '0;
      rsp_result <= '0;
      rsp_tag    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            f3_q    <= req_funct3;
            rs1_q   <= req_rs1;
            rs2_q   <= req_rs2;
            op_q    <= req_op;
            rsp_tag <= req_tag;
            if (req_spec) begin
              rsp_result <= spec_res;
              state      <= RESP;
            end else if (hit) begin
              rsp_result <= hit_res;
              state <= (req_funct3 == F_MULHSU) ? FIX : RESP;
            end else begin
              state <= LAUNCH;
            end
          end
        end
        LAUNCH: state <= WAIT;
        WAIT: begin
          if (!mc_busy) begin
            rsp_result <= cap_res;
            state <= (f3_q == F_MULHSU) ? FIX : RESP;
          end
        end
        FIX: begin
          rsp_result <= rsp_result
                      - (rs1_q[31] ? rs2_q : 32'd0);
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: scoreboard bench with a behavioural 4-step mul/div unit.
// Expected results and latencies are hand-computed constants.
module tb_mdu_sequencer;

  localparam int TAGW = 5;

`ifdef MDU_RESULT_CACHE_EN
  localparam int L_MUL2  = 1;
  localparam int L_MULHU = 1;
  localparam int L_REM2  = 1;
`else
  localparam int L_MUL2  = 7;
  localparam int L_MULHU = 7;
  localparam int L_REM2  = 7;
`endif

  logic            CLK = 1'b0;
  logic            RESETn;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [31:0]     req_rs1;
  logic [31:0]     req_rs2;
  logic [TAGW-1:0] req_tag;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_result;
  logic [TAGW-1:0] rsp_tag;
  logic            mc_reset;
  logic            mc_start;
  logic [1:0]      mc_op;
  logic [31:0]     mc_op1;
  logic [31:0]     mc_op2;
  logic [31:0]     mc_result1;
  logic [31:0]     mc_result2;
  logic            mc_busy;

  mdu_sequencer #(.TAGW(TAGW)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag),
    .mc_reset(mc_reset), .mc_start(mc_start),
    .mc_op(mc_op), .mc_op1(mc_op1), .mc_op2(mc_op2),
    .mc_result1(mc_result1), .mc_result2(mc_result2),
    .mc_busy(mc_busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural unit: Start -> Busy for 4 cycles, result at completion
  function automatic logic [63:0] unit_calc(
    input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [31:0] q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      2'd0: return sa * sb;
      2'd1: return {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0) return 64'd0;
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 0) return 64'd0;
        return {a % b, a / b};
      end
    endcase
  endfunction

  logic [2:0] ucnt;
  always @(posedge CLK) begin
    if (mc_reset) begin
      mc_busy    <= 1'b0;
      ucnt       <= '0;
      mc_result1 <= '0;
      mc_result2 <= '0;
    end else if (mc_busy) begin
      ucnt <= ucnt + 3'd1;
      if (ucnt == 3'd3) begin
        mc_busy <= 1'b0;
        {mc_result2, mc_result1} <= unit_calc(mc_op, mc_op1, mc_op2);
      end
    end else if (mc_start) begin
      mc_busy <= 1'b1;
      ucnt    <= '0;
    end
  end

  int start_cnt = 0;
  always @(negedge CLK) if (mc_start === 1'b1) start_cnt++;

  typedef struct {
    logic [31:0]     res;
    logic [TAGW-1:0] tag;
    int              lat;
    int              acc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: latency on first RESP cycle, hold under back-pressure, pop on handshake
  bit              seen = 0;
  bit              chk_idle = 0;
  logic [31:0]     held_res;
  logic [TAGW-1:0] held_tag;
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESETn !== 1'b1) begin
        seen = 0;
        chk_idle = 0;
      end else begin
        if (chk_idle) begin
          chk_idle = 0;
          check("idle_after_rsp", 32'(req_ready), 32'd1);
        end
        if (rsp_valid === 1'b1) begin
          if (!seen) begin
            if (sb.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_rsp got=%h tag=%0d want=none",
                       rsp_result, rsp_tag);
            end else begin
              check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
            end
            check("ready_low_in_rsp", 32'(req_ready), 32'd0);
            seen = 1;
            held_res = rsp_result;
            held_tag = rsp_tag;
          end else begin
            check("hold_result", rsp_result, held_res);
            check("hold_tag", 32'(rsp_tag), 32'(held_tag));
            check("ready_low_bp", 32'(req_ready), 32'd0);
          end
          if (rsp_ready === 1'b1) begin
            if (sb.size() > 0) begin
              e = sb.pop_front();
              check("result", rsp_result, e.res);
              check("tag", 32'(rsp_tag), 32'(e.tag));
            end
            seen = 0;
            chk_idle = 1;
          end
        end
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAGW-1:0] tg,
                       input logic [31:0] er, input int el, input bit push);
    int n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (req_ready !== 1'b1 && n < 100);
    if (req_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout got=req_ready_low want=ready tag=%0d", tg);
      return;
    end
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_rs1    = a;
    req_rs2    = b;
    req_tag    = tg;
    if (push) sb.push_back('{er, tg, el, cyc});
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge CLK);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d want=0 pending", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
    check({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({pfx, "_rsp_result"}, rsp_result, 32'd0);
    check({pfx, "_rsp_tag"}, 32'(rsp_tag), 32'd0);
    check({pfx, "_mc_start"}, 32'(mc_start), 32'd0);
    check({pfx, "_mc_op"}, 32'(mc_op), 32'd0);
    check({pfx, "_mc_op1"}, mc_op1, 32'd0);
    check({pfx, "_mc_op2"}, mc_op2, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    RESETn     = 1'b0;
    req_valid  = 1'b0;
    req_funct3 = '0;
    req_rs1    = '0;
    req_rs2    = '0;
    req_tag    = '0;
    rsp_ready  = 1'b1;

    @(negedge CLK);
    check("mc_reset_low", 32'(mc_reset), 32'd1);
    @(posedge CLK);
    #1;
    RESETn = 1'b1;
    @(negedge CLK);
    check_reset_vals("rst");
    check("mc_reset_high", 32'(mc_reset), 32'd0);

    // funct3: 000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
    issue(3'b001, 32'hFFFF_FFFE, 32'h3, 5'd1, 32'hFFFF_FFFF, 7, 1);
    issue(3'b000, 32'hFFFF_FFFE, 32'h3, 5'd2, 32'hFFFF_FFFA, L_MUL2, 1);
    issue(3'b010, 32'h8000_0000, 32'h2, 5'd3, 32'hFFFF_FFFF, 8, 1);
    issue(3'b011, 32'h8000_0000, 32'h2, 5'd4, 32'h0000_0001, L_MULHU, 1);
    drain();

    s0 = start_cnt;
    issue(3'b101, 32'h1234_5678, 32'h0, 5'd5, 32'hFFFF_FFFF, 1, 1);
    drain();
    check("divu0_no_start", 32'(start_cnt - s0), 32'd0);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h0, 1, 1);
    issue(3'b111, 32'd55, 32'h0, 5'd11, 32'd55, 1, 1);

    issue(3'b100, 32'hFFFF_FFF9, 32'h2, 5'd7, 32'hFFFF_FFFD, 7, 1);
    issue(3'b110, 32'hFFFF_FFF9, 32'h2, 5'd8, 32'hFFFF_FFFF, L_REM2, 1);
    issue(3'b010, 32'h0000_0003, 32'h5, 5'd12, 32'h0, 8, 1);
    drain();

    // Back-pressure: hold RESP for 10 cycles
    @(posedge CLK);
    #1;
    rsp_ready = 1'b0;
    issue(3'b111, 32'd100, 32'd7, 5'd9, 32'd2, 7, 1);
    begin
      int n = 0;
      while (rsp_valid !== 1'b1 && n < 50) begin
        @(posedge CLK);
        #1;
        n++;
      end
      check("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    end
    repeat (10) @(posedge CLK);
    #1;
    rsp_ready = 1'b1;
    drain();

    // Reset during WAIT discards the operation
    issue(3'b000, 32'd5, 32'd6, 5'd13, 32'd30, 7, 0);
    @(posedge CLK);
    #1;
    check("wait_mc_start", 32'(mc_start), 32'd1);
    RESETn = 1'b0;
    @(negedge CLK);
    check("mid_mc_reset", 32'(mc_reset), 32'd1);
    @(posedge CLK);
    #1;
    RESETn = 1'b1;
    check_reset_vals("mid");
    repeat (15) @(posedge CLK);
    issue(3'b101, 32'd100, 32'd7, 5'd10, 32'd14, 7, 1);
    drain();
    repeat (3) @(posedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Sequencer that sits between the execute stage and the multi-cycle multiply/divide unit. It accepts RISC-V M-extension requests over a valid/ready handshake and maps the eight funct3 operations onto the unit's four ops. It resolves divide-by-zero and signed overflow without launching the unit, and post-corrects MULHSU. It holds the unit's operands stable for the whole operation and returns a single 32-bit result with its destination tag.

## Interface
- `TAGW`, default 5: width of the destination-register tag carried through with each request.
- `CLK` in 1: clock, rising edge.
- `RESETn` in 1: synchronous reset, active low.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request.
- `req_funct3` in 3: M-extension funct3 (000 MUL … 111 REMU).
- `req_rs1`, `req_rs2` in 32: source operands.
- `req_tag` in TAGW: destination tag.
- `rsp_valid` out 1: result present.
- `rsp_ready` in 1: consumer takes the result.
- `rsp_result` out 32: final result.
- `rsp_tag` out TAGW: tag of the completed request.
- `mc_reset` out 1: active-high reset to the unit; equals `~RESETn`.
- `mc_start`, `mc_op[1:0]`, `mc_op1[31:0]`, `mc_op2[31:0]` out: drive the unit's `Start`, `MCycleOp`, `Operand1`, `Operand2`.
- `mc_result1`, `mc_result2` in 32: unit LSW/quotient and MSW/remainder.
- `mc_busy` in 1: unit's Busy.

## Operation
- **States:** IDLE, LAUNCH, WAIT, FIX, RESP.
- **IDLE:**
  - `req_ready=1`.
  - On `req_valid`, latch funct3, rs1, rs2 and tag.
  - Go to RESP when the request is a special case, otherwise to LAUNCH.
- **Op mapping:**
  - MUL and MULH use op 00.
  - MULHU and MULHSU use op 01.
  - DIV and REM use op 10.
  - DIVU and REMU use op 11.
- **Result selection:**
  - MUL takes `mc_result1`; MULH, MULHU and MULHSU take `mc_result2`.
  - DIV and DIVU take `mc_result1`; REM and REMU take `mc_result2`.
- **Special cases (the unit is not started):**
  - rs2==0, divide class: quotient 0xFFFFFFFF; remainder = rs1.
  - Signed divide with rs1==0x80000000 and rs2==0xFFFFFFFF: quotient 0x80000000; remainder 0.
- **LAUNCH:** `mc_start=1`. Go to WAIT.
- **WAIT:**
  - `mc_start=1` while `mc_busy=1`.
  - On the first WAIT cycle with `mc_busy=0`, capture the selected result and drive `mc_start=0` combinationally.
  - Go to FIX for MULHSU, otherwise to RESP.
- **FIX (MULHSU only):** result = captured unsigned high word − (rs1[31] ? rs2 : 0), modulo 2^32.
- **RESP:**
  - `rsp_valid=1`; result and tag are held stable.
  - On `rsp_ready`, return to IDLE.
  - No new request is accepted in the same cycle.
- **Operand hold:** `mc_op`, `mc_op1` and `mc_op2` are driven from latched registers and stay constant from LAUNCH through the capture cycle. The unit samples operand signs at completion.
- **Reset:**
  - While RESETn=0 the sequencer goes to IDLE on the next edge and `mc_reset=1`.
  - All latched state is cleared.
  - An in-flight operation is discarded and never responded to.

## Timing
- **Reset values:**
  - `req_ready=1`, `rsp_valid=0`, `rsp_result=0`, `rsp_tag=0`.
  - `mc_start=0`, `mc_op=0`, `mc_op1=0`, `mc_op2=0`.
  - `mc_reset=1` while RESETn is low.
- **Special-case latency:** accept in cycle N; `rsp_valid` in cycle N+1.
- **Unit latency:** `rsp_valid` appears 1 cycle after the capture cycle, or 2 cycles for MULHSU. With the unit's 4-step datapath, total latency is 7 cycles (8 for MULHSU), independent of operand values.
- **Back-pressure:** `rsp_ready` held low keeps RESP indefinitely; outputs are stable.
- **Throughput:** at most one request in flight. `req_ready=0` in every state except IDLE.
- **`mc_start` deassertion:** it must be low no later than the cycle after capture, so the unit never relaunches.

## Configuration
- **Macro:** `MDU_RESULT_CACHE_EN`.
- **Defined:**
  - On every unit completion, store rs1, rs2, `mc_op`, and both `mc_result1` and `mc_result2`.
  - A later request that maps to the same `mc_op` with identical rs1 and rs2 hits, for example MULH followed by MUL, or DIV followed by REM.
  - On a hit, skip LAUNCH and WAIT: go to RESP (via FIX for MULHSU), so latency is 1 cycle (2 for MULHSU).
  - The cache is invalidated by reset and by any special-case request.
- **Undefined:** no cache storage exists; every non-special request launches the unit.

## Test plan
- **Signed MUL/MULH:** MULH rs1=0xFFFFFFFE (−2), rs2=0x00000003 → result 0xFFFFFFFF, 7 cycles. Then MUL with the same operands → 0xFFFFFFFA. This MUL takes 1 cycle with the cache macro defined, 7 without.
- **MULHSU correction:** MULHSU rs1=0x80000000, rs2=0x00000002 → 0xFFFFFFFF, latency 8. MULHU with the same operands → 0x00000001.
- **Division special cases:**
  - DIVU rs1=0x12345678, rs2=0 → 0xFFFFFFFF in 1 cycle; `mc_start` never asserted.
  - REM rs1=0x80000000, rs2=0xFFFFFFFF → 0x00000000.
- **Signed divide:** DIV rs1=0xFFFFFFF9 (−7), rs2=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF.
- **Back-pressure:** hold `rsp_ready=0` for 10 cycles in RESP → `rsp_result` and `rsp_tag` are constant and `req_ready=0`. Release → IDLE on the next cycle.
- **Reset mid-operation:** drop RESETn for 1 cycle during WAIT → IDLE with all outputs at reset values and `mc_reset=1` for that cycle. No response is produced; the next DIVU 100/7 returns 14.
